hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have port `load_valid`: input, 1 bit, requester offers a new 6-digit value.
REQ-004 The block SHALL have port `load_ready`: output, 1 bit, block can accept a value.
REQ-005 The block SHALL have port `load_data`: input, 24 bits, six BCD digits; [4k+3:4k] = digit k, driving hexk.
REQ-006 The block SHALL have port `bcd`: output, 4 bits, driven to the shared combinational seg7 decoder input.
REQ-007 The block SHALL have port `leds`: input, 7 bits, decoder output; active-high segments, bit order 6543210.
REQ-008 The block SHALL have ports `hex0`..`hex5`: output, 7 bits each, registered, active-low segment drives (0 = lit).
REQ-009 The block SHALL have port `busy`: output, 1 bit, high in SCAN and DONE.
REQ-010 The block SHALL have port `done`: output, 1 bit, one-cycle pulse when all six digits are updated.

Function
REQ-011 The block SHALL have an FSM with states IDLE, SCAN and DONE, plus a 3-bit digit index idx and a 24-bit shadow register.
REQ-012 `load_ready` SHALL equal (state == IDLE), and `busy` SHALL equal (state != IDLE).
REQ-013 Handshake: on an edge where load_valid && load_ready, the block SHALL copy load_data into shadow, set idx = 5, and go IDLE -> SCAN.
REQ-014 load_valid while not ready SHALL be ignored; the requester must hold it until accepted.
REQ-015 In SCAN, bcd SHALL equal shadow digit idx, combinationally.
REQ-016 On each SCAN edge, hex[idx] SHALL be updated as follows:
  - ~leds, when the digit is <= 9;
  - 7'h7F (blank), when the digit is > 9.
REQ-017 After each SCAN update, idx SHALL decrement; the scan order is digit 5 down to digit 0.
REQ-018 The edge that updates digit 0 SHALL move SCAN -> DONE.
REQ-019 DONE SHALL last exactly one cycle with done = 1, then go DONE -> IDLE unconditionally.
REQ-020 Latency: with the accepting edge at end of cycle 0, SCAN SHALL occupy cycles 1-6, done SHALL be high in cycle 7, and load_ready SHALL be 1 again in cycle 8.
REQ-021 Digits not yet rescanned SHALL hold their previous values; there is no global blanking during a scan.
REQ-022 In IDLE and DONE, bcd SHALL be 4'd0, and the hex registers SHALL hold their values.

Reset
REQ-023 While reset_n = 0, the block SHALL immediately force:
  - state IDLE, idx 0, shadow 0;
  - hex0..hex5 = 7'h7F;
  - done 0, busy 0, load_ready 1, bcd 0.
REQ-024 Reset asserted mid-SCAN or in DONE SHALL abort the scan with no done pulse; partial updates are lost (all digits blank).
REQ-025 After reset_n rises, the first handshake SHALL be accepted on the next edge on which load_valid = 1.

Configuration
REQ-026 When macro LEADING_ZERO_BLANK_EN is defined, the block SHALL keep a flag seen_nz, cleared at handshake and set by any nonzero digit.
REQ-027 With LEADING_ZERO_BLANK_EN defined, a zero digit at idx 5..1 scanned while seen_nz = 0 SHALL be written as 7'h7F.
REQ-028 With LEADING_ZERO_BLANK_EN defined, digit 0 SHALL never be leading-blanked.
REQ-029 Without LEADING_ZERO_BLANK_EN, the block SHALL display zero digits as "0" (7'b1000000), and the seen_nz logic SHALL be absent.

Verification
REQ-030 The bench SHALL cover reset: reset_n = 0 -> all hex = 7'h7F, load_ready = 1, busy = 0, done = 0.
REQ-031 The bench SHALL cover a normal load: load 24'h012345 -> bcd sequence 0,1,2,3,4,5 in cycles 1-6, done in cycle 7, and:
  - hex5 = 7'b1000000 (macro off) or 7'h7F (macro on);
  - hex4 = 7'b1111001;
  - hex0 = 7'b0010010.
REQ-032 The bench SHALL cover an invalid digit: load 24'h99999A -> hex0 = 7'h7F, and hex5..hex1 = 7'b0010000.
REQ-033 The bench SHALL cover back-pressure: hold load_valid high with 24'h111111, then 24'h222222 from cycle 2 -> the second value is not accepted until cycle 8, and the final hexes show "2" (7'b0100100).
REQ-034 The bench SHALL cover reset mid-scan: pulse reset_n low in cycle 3 of a scan of 24'h888888 -> all hex = 7'h7F, no done pulse, IDLE.
REQ-035 The bench SHALL cover all zeros with LEADING_ZERO_BLANK_EN: load 24'h000000 -> hex5..hex1 = 7'h7F, hex0 = 7'b1000000.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Six-digit seven-segment scan controller: latches a 6-digit BCD value, walks a shared
// decoder over digits 5..0 and registers each result. Optional macro: LEADING_ZERO_BLANK_EN.
module hex_scan_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] load_data,
    output logic [3:0]  bcd,
    input  logic [6:0]  leds,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [23:0]     r_shadow;
    logic [5:0][6:0] r_hex;

    logic [3:0]      w_digit;
    logic [6:0]      w_seg;

    assign w_digit = r_shadow[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic r_seen_nz;
    logic w_lead_blank;

    // Digit 0 is always shown so an all-zero value still reads "0".
    assign w_lead_blank = !r_seen_nz && (w_digit == 4'd0) && (r_idx != 3'd0);
`endif

    always_comb begin
        w_seg = (w_digit > 4'd9) ? SEG_BLANK : ~leds;
`ifdef LEADING_ZERO_BLANK_EN
        if (w_lead_blank) begin
            w_seg = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_idx    <= 3'd0;
            r_shadow <= 24'd0;
            r_hex    <= {6{SEG_BLANK}};
`ifdef LEADING_ZERO_BLANK_EN
            r_seen_nz <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_shadow <= load_data;
                        r_idx    <= 3'd5;
                        r_state  <= SCAN;
`ifdef LEADING_ZERO_BLANK_EN
                        r_seen_nz <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    r_hex[r_idx] <= w_seg;
`ifdef LEADING_ZERO_BLANK_EN
                    r_seen_nz <= r_seen_nz | (w_digit != 4'd0);
`endif
                    if (r_idx == 3'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 3'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from the state register, so reset forces them at once.
    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign bcd        = (r_state == SCAN) ? w_digit : 4'd0;

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl with a behavioural seg7 decoder and a scoreboard of expected
// bcd sequences and final hex patterns.
module tb_hex_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [23:0] load_data;
    logic [3:0]  bcd;
    logic [6:0]  leds;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_bcd_q[$];
    logic [41:0] exp_hex_q[$];

    wire [41:0] hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    hex_scan_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd        (bcd),
        .leds       (leds),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high segments, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign leds = seg7(bcd);

    function automatic logic [41:0] model_hex(input logic [23:0] d);
        logic [41:0] r;
        logic        seen;
        logic [3:0]  dg;
        logic [6:0]  v;
        r    = '0;
        seen = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            dg = d[4*k +: 4];
            if (dg > 4'd9) v = 7'h7F;
            else v = ~seg7(dg);
`ifdef LEADING_ZERO_BLANK_EN
            if (dg == 4'd0 && !seen && k != 0) v = 7'h7F;
`endif
            if (dg != 4'd0) seen = 1'b1;
            r[7*k +: 7] = v;
        end
        return r;
    endfunction

    function automatic logic [23:0] model_bcd(input logic [23:0] d);
        logic [23:0] s;
        for (int i = 0; i < 6; i++) s[4*i +: 4] = d[4*(5-i) +: 4];
        return s;
    endfunction

    task automatic start_load(input logic [23:0] d);
        exp_bcd_q.push_back(model_bcd(d));
        exp_hex_q.push_back(model_hex(d));
        load_data  = d;
        load_valid = 1'b1;
    endtask

    // Samples cycles 1..8 after an accepting edge; caller is at the start of cycle 1.
    task automatic collect(output logic [23:0] ob, output logic [5:0] obz,
                           output logic dn7, output logic rdy8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ob[4*i +: 4] = bcd;
            obz[i]       = busy & ~done & ~load_ready;
        end
        @(negedge clk);
        dn7 = done;
        @(negedge clk);
        rdy8 = load_ready & ~done & ~busy;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(negedge clk);
        checks++; if (hex_all !== {6{7'h7F}}) begin failures++; $display("FAIL reset_hex got=%h exp=%h", hex_all, {6{7'h7F}}); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (bcd !== 4'd0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal;
        logic [23:0] ob, eb;
        logic [5:0]  obz;
        logic        dn, rdy;
        logic [41:0] eh;
        start_load(24'h012345);
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL normal_ready0 got=%b exp=1", load_ready); end
        @(posedge clk); #1 load_valid = 1'b0;
        collect(ob, obz, dn, rdy);
        eb = exp_bcd_q.pop_front();
        eh = exp_hex_q.pop_front();
        checks++; if (ob !== eb) begin failures++; $display("FAIL normal_bcd_seq got=%h exp=%h", ob, eb); end
        checks++; if (obz !== 6'h3F) begin failures++; $display("FAIL normal_scan_busy got=%b exp=111111", obz); end
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL normal_done7 got=%b exp=1", dn); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL normal_ready8 got=%b exp=1", rdy); end
        checks++; if (hex_all !== eh) begin failures++; $display("FAIL normal_hex got=%h exp=%h", hex_all, eh); end
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (hex5 !== 7'h7F) begin failures++; $display("FAIL normal_hex5 got=%b exp=%b", hex5, 7'h7F); end
`else
        checks++; if (hex5 !== 7'b1000000) begin failures++; $display("FAIL normal_hex5 got=%b exp=%b", hex5, 7'b1000000); end
`endif
        checks++; if (hex4 !== 7'b1111001) begin failures++; $display("FAIL normal_hex4 got=%b exp=1111001", hex4); end
        checks++; if (hex0 !== 7'b0010010) begin failures++; $display("FAIL normal_hex0 got=%b exp=0010010", hex0); end
    endtask

    task automatic test_invalid_digit;
        logic [23:0] ob, eb;
        logic [5:0]  obz;
        logic        dn, rdy;
        logic [41:0] eh;
        start_load(24'h99999A);
        @(posedge clk); #1 load_valid = 1'b0;
        collect(ob, obz, dn, rdy);
        eb = exp_bcd_q.pop_front();
        eh = exp_hex_q.pop_front();
        checks++; if (ob !== eb) begin failures++; $display("FAIL invalid_bcd_seq got=%h exp=%h", ob, eb); end
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL invalid_done got=%b exp=1", dn); end
        checks++; if (hex_all !== eh) begin failures++; $display("FAIL invalid_hex got=%h exp=%h", hex_all, eh); end
        checks++; if (hex0 !== 7'h7F) begin failures++; $display("FAIL invalid_hex0 got=%b exp=1111111", hex0); end
        checks++; if (hex1 !== 7'b0010000 || hex5 !== 7'b0010000) begin failures++; $display("FAIL invalid_hex15 got=%b/%b exp=0010000", hex1, hex5); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] ob, eb;
        logic [5:0]  obz;
        logic        dn, rdy;
        logic [41:0] eh;
        logic [31:0] rdy_hist;
        logic [7:0]  done_hist;
        start_load(24'h111111);
        @(posedge clk); #1;
        ob = '0; rdy_hist = '0; done_hist = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) start_load(24'h222222);
            @(negedge clk);
            if (c <= 6) ob[4*(c-1) +: 4] = bcd;
            rdy_hist[c]  = load_ready;
            done_hist[c-1] = done;
            if (c == 7) begin
                eh = exp_hex_q.pop_front();
                checks++; if (hex_all !== eh) begin failures++; $display("FAIL b2b_first_hex got=%h exp=%h", hex_all, eh); end
            end
            if (c < 8) begin
                @(posedge clk); #1;
            end
        end
        eb = exp_bcd_q.pop_front();
        checks++; if (ob !== eb) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=%h", ob, eb); end
        checks++; if (rdy_hist[8:1] !== 8'b1000_0000) begin failures++; $display("FAIL b2b_ready_hist got=%b exp=10000000", rdy_hist[8:1]); end
        checks++; if (done_hist !== 8'b0100_0000) begin failures++; $display("FAIL b2b_done_hist got=%b exp=01000000", done_hist); end
        @(posedge clk); #1 load_valid = 1'b0;
        collect(ob, obz, dn, rdy);
        eb = exp_bcd_q.pop_front();
        eh = exp_hex_q.pop_front();
        checks++; if (ob !== eb) begin failures++; $display("FAIL b2b_second_bcd got=%h exp=%h", ob, eb); end
        checks++; if (dn !== 1'b1 || rdy !== 1'b1) begin failures++; $display("FAIL b2b_second_done_ready got=%b%b exp=11", dn, rdy); end
        checks++; if (hex_all !== eh) begin failures++; $display("FAIL b2b_second_hex got=%h exp=%h", hex_all, eh); end
        checks++; if (hex3 !== 7'b0100100) begin failures++; $display("FAIL b2b_hex3 got=%b exp=0100100", hex3); end
    endtask

    task automatic test_reset_mid_scan;
        logic [41:0] eh;
        int          done_seen;
        int          busy_seen;
        start_load(24'h888888);
        @(posedge clk); #1 load_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_bcd_q.delete();
        exp_hex_q.delete();
        exp_hex_q.push_back({6{7'h7F}});
        #2;
        eh = exp_hex_q.pop_front();
        checks++; if (hex_all !== eh) begin failures++; $display("FAIL midrst_hex got=%h exp=%h", hex_all, eh); end
        checks++; if (busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0 || bcd !== 4'd0)
            begin failures++; $display("FAIL midrst_ctrl got=busy%b rdy%b done%b bcd%h exp=busy0 rdy1 done0 bcd0", busy, load_ready, done, bcd); end
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        checks++; if (done_seen != 0 || busy_seen != 0) begin failures++; $display("FAIL midrst_after got=done%0d busy%0d exp=0 0", done_seen, busy_seen); end
        checks++; if (hex_all !== {6{7'h7F}}) begin failures++; $display("FAIL midrst_hex_hold got=%h exp=%h", hex_all, {6{7'h7F}}); end
    endtask

    task automatic test_all_zeros;
        logic [23:0] ob, eb;
        logic [5:0]  obz;
        logic        dn, rdy;
        logic [41:0] eh;
        start_load(24'h000000);
        @(posedge clk); #1 load_valid = 1'b0;
        collect(ob, obz, dn, rdy);
        eb = exp_bcd_q.pop_front();
        eh = exp_hex_q.pop_front();
        checks++; if (obz[0] !== 1'b1) begin failures++; $display("FAIL zeros_first_accept got=%b exp=1", obz[0]); end
        checks++; if (ob !== eb) begin failures++; $display("FAIL zeros_bcd got=%h exp=%h", ob, eb); end
        checks++; if (hex_all !== eh) begin failures++; $display("FAIL zeros_hex got=%h exp=%h", hex_all, eh); end
        checks++; if (hex0 !== 7'b1000000) begin failures++; $display("FAIL zeros_hex0 got=%b exp=1000000", hex0); end
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (hex1 !== 7'h7F || hex5 !== 7'h7F) begin failures++; $display("FAIL zeros_lead got=%b/%b exp=1111111", hex1, hex5); end
`else
        checks++; if (hex1 !== 7'b1000000 || hex5 !== 7'b1000000) begin failures++; $display("FAIL zeros_lead got=%b/%b exp=1000000", hex1, hex5); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal();
        test_invalid_digit();
        test_back_to_back();
        test_reset_mid_scan();
        test_all_zeros();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
